// File: rtl/alu_req_scheduler.sv
// Round-robin scheduler that shares one ALU among NUM_REQ requesters.
// Accepts one op per handshake, waits the ALU latency, returns the tagged result.
module alu_req_scheduler #(
    parameter int NUM_REQ      = 4,
    parameter int DATA_WIDTH   = 8,
    parameter int CMD_WIDTH    = 4,
    parameter int RESULT_WIDTH = 16,
    parameter int ALU_LAT      = 1,
    parameter int MUL_LAT      = 2,
    parameter int MUL_CMD0     = 9,
    parameter int MUL_CMD1     = 10,
    localparam int IDW         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [NUM_REQ-1:0]              req_mode,
    input  logic [NUM_REQ-1:0]              req_cin,
    input  logic [NUM_REQ*CMD_WIDTH-1:0]    req_cmd,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_opa,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_opb,
    output logic                            alu_ce,
    output logic                            alu_mode,
    output logic                            alu_cin,
    output logic [CMD_WIDTH-1:0]            alu_cmd,
    output logic [DATA_WIDTH-1:0]           alu_opa,
    output logic [DATA_WIDTH-1:0]           alu_opb,
    output logic [1:0]                      alu_inp_valid,
    input  logic [RESULT_WIDTH-1:0]         alu_res,
    input  logic [5:0]                      alu_flags,
    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic [IDW-1:0]                  rsp_id,
    output logic [RESULT_WIDTH-1:0]         rsp_res,
    output logic [5:0]                      rsp_flags,
    output logic                            busy
);

    localparam int LMAX = (ALU_LAT > MUL_LAT) ? ALU_LAT : MUL_LAT;
    localparam int CNW  = $clog2(LMAX + 1);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t          state_q;
    logic [IDW-1:0]  rr_q;
    logic [IDW-1:0]  id_q;
    logic [CNW-1:0]  cnt_q;

    logic                  found;
    logic [IDW-1:0]        grant;
    logic [IDW:0]          idx;
    logic                  g_mode;
    logic                  g_cin;
    logic [CMD_WIDTH-1:0]  g_cmd;
    logic [DATA_WIDTH-1:0] g_opa;
    logic [DATA_WIDTH-1:0] g_opb;
    logic                  g_mul;

    // First valid requester at or after rr_q, wrapping.
    always_comb begin
        found = 1'b0;
        grant = rr_q;
        idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = {1'b0, rr_q} + (IDW+1)'(k);
            if (idx >= (IDW+1)'(NUM_REQ))
                idx = idx - (IDW+1)'(NUM_REQ);
            if (!found && req_valid[idx[IDW-1:0]]) begin
                found = 1'b1;
                grant = idx[IDW-1:0];
            end
        end
    end

    always_comb begin
        g_mode = 1'b0;
        g_cin  = 1'b0;
        g_cmd  = '0;
        g_opa  = '0;
        g_opb  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant == IDW'(i)) begin
                g_mode = req_mode[i];
                g_cin  = req_cin[i];
                g_cmd  = req_cmd[i*CMD_WIDTH +: CMD_WIDTH];
                g_opa  = req_opa[i*DATA_WIDTH +: DATA_WIDTH];
                g_opb  = req_opb[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign g_mul = g_mode && (g_cmd == CMD_WIDTH'(MUL_CMD0) ||
                              g_cmd == CMD_WIDTH'(MUL_CMD1));

    always_comb begin
        req_ready = '0;
        if (state_q == IDLE && found)
            req_ready[grant] = 1'b1;
    end

    assign busy = (state_q != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            rr_q          <= '0;
            id_q          <= '0;
            cnt_q         <= '0;
            alu_ce        <= 1'b0;
            alu_mode      <= 1'b0;
            alu_cin       <= 1'b0;
            alu_cmd       <= '0;
            alu_opa       <= '0;
            alu_opb       <= '0;
            alu_inp_valid <= 2'b00;
            rsp_valid     <= 1'b0;
            rsp_id        <= '0;
            rsp_res       <= '0;
            rsp_flags     <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (found) begin
                        alu_ce        <= 1'b1;
                        alu_inp_valid <= 2'b11;
                        alu_mode      <= g_mode;
                        alu_cin       <= g_cin;
                        alu_cmd       <= g_cmd;
                        alu_opa       <= g_opa;
                        alu_opb       <= g_opb;
                        id_q          <= grant;
                        rr_q          <= (grant == IDW'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
                        cnt_q         <= g_mul ? CNW'(MUL_LAT) : CNW'(ALU_LAT);
                        state_q       <= EXEC;
                    end
                end
                EXEC: begin
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CNW'(1)) begin
                        alu_ce        <= 1'b0;
                        alu_inp_valid <= 2'b00;
                        rsp_res       <= alu_res;
                        rsp_flags     <= alu_flags;
                        rsp_id        <= id_q;
                        rsp_valid     <= 1'b1;
                        state_q       <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_req_scheduler.sv
// Bench for alu_req_scheduler: directed vector table, corner sequences,
// and randomized traffic against a transaction-level model.
module tb_alu_req_scheduler;

    localparam int N = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [3:0]    req_valid = '0;
    logic [3:0]    req_ready;
    logic [3:0]    req_mode = '0;
    logic [3:0]    req_cin = '0;
    logic [15:0]   req_cmd = '0;
    logic [31:0]   req_opa = '0;
    logic [31:0]   req_opb = '0;
    logic          alu_ce, alu_mode, alu_cin;
    logic [3:0]    alu_cmd;
    logic [7:0]    alu_opa, alu_opb;
    logic [1:0]    alu_inp_valid;
    logic [15:0]   alu_res;
    logic [5:0]    alu_flags;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [1:0]    rsp_id;
    logic [15:0]   rsp_res;
    logic [5:0]    rsp_flags;
    logic          busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_req_scheduler #(
        .NUM_REQ(4), .DATA_WIDTH(8), .CMD_WIDTH(4), .RESULT_WIDTH(16),
        .ALU_LAT(1), .MUL_LAT(2), .MUL_CMD0(9), .MUL_CMD1(10)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_mode(req_mode), .req_cin(req_cin), .req_cmd(req_cmd),
        .req_opa(req_opa), .req_opb(req_opb),
        .alu_ce(alu_ce), .alu_mode(alu_mode), .alu_cin(alu_cin),
        .alu_cmd(alu_cmd), .alu_opa(alu_opa), .alu_opb(alu_opb),
        .alu_inp_valid(alu_inp_valid), .alu_res(alu_res), .alu_flags(alu_flags),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_res(rsp_res), .rsp_flags(rsp_flags), .busy(busy)
    );

    // Toy ALU: {flags, res}; mul for arith 9/10, add for other arith, and/xor for logic.
    function automatic logic [21:0] alu_fn(input logic m, input logic ci,
                                           input logic [3:0] c,
                                           input logic [7:0] a, input logic [7:0] b);
        logic [15:0] r;
        logic [8:0]  s;
        logic        co;
        co = 1'b0;
        s  = {1'b0, a} + {1'b0, b} + {8'h00, ci};
        if (m && (c == 4'd9 || c == 4'd10)) r = {8'h00, a} * {8'h00, b};
        else if (m) begin r = {7'h00, s}; co = s[8]; end
        else r = {8'h00, (a & b) ^ {4'h0, c}};
        return {1'b0, m, co, a > b, a < b, a == b, r};
    endfunction

    function automatic int lat_of(input logic m, input logic [3:0] c);
        return (m && (c == 4'd9 || c == 4'd10)) ? 2 : 1;
    endfunction

    // ALU result is only correct on its final latency cycle; otherwise inverted.
    logic [3:0]  ce_run_q = '0;
    logic [21:0] alu_good;
    always @(posedge clk) ce_run_q <= alu_ce ? ce_run_q + 4'd1 : 4'd0;
    assign alu_good = alu_fn(alu_mode, alu_cin, alu_cmd, alu_opa, alu_opb);
    assign {alu_flags, alu_res} =
        (alu_ce && alu_inp_valid == 2'b11 &&
         int'(ce_run_q) + 1 == lat_of(alu_mode, alu_cmd)) ? alu_good : ~alu_good;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic set_req(input int id, input logic m, input logic ci,
                           input logic [3:0] c, input logic [7:0] a, input logic [7:0] b);
        req_mode[2'(id)]   = m;
        req_cin[2'(id)]    = ci;
        req_cmd[id*4 +: 4] = c;
        req_opa[id*8 +: 8] = a;
        req_opb[id*8 +: 8] = b;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
    endtask

    task automatic wait_grant(output int g);
        int n;
        n = 0;
        g = -1;
        while (req_ready == 4'b0 && n < 20) begin @(negedge clk); #1; n++; end
        for (int i = 0; i < N; i++) if (req_ready[2'(i)]) g = i;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 20) begin @(negedge clk); #1; n++; end
        chk("idle", 32'(busy), 32'd0);
    endtask

    typedef struct {
        int         id;
        logic       m;
        logic       ci;
        logic [3:0] c;
        logic [7:0] a;
        logic [7:0] b;
        logic [15:0] res;
        logic [5:0] flg;
        int         lat;
    } vec_t;

    task automatic run_vec(input vec_t v);
        int n, ce;
        set_req(v.id, v.m, v.ci, v.c, v.a, v.b);
        req_valid = 4'(1) << v.id;
        #1;
        n = 0;
        while (req_ready == 4'b0 && n < 10) begin @(negedge clk); #1; n++; end
        chk("vec_ready", 32'(req_ready), 32'(4'(1) << v.id));
        @(negedge clk);
        req_valid = '0;
        #1;
        ce = 0;
        n  = 0;
        while (!rsp_valid && n < 10) begin
            if (alu_ce) ce++;
            @(negedge clk); #1; n++;
        end
        chk("vec_ce_cycles", 32'(ce), 32'(v.lat));
        chk("vec_rsp_time", 32'(n), 32'(v.lat));
        chk("vec_rsp_id", 32'(rsp_id), 32'(v.id));
        chk("vec_rsp_res", 32'(rsp_res), 32'(v.res));
        chk("vec_rsp_flags", 32'(rsp_flags), 32'(v.flg));
        @(negedge clk);
        #1;
        chk("vec_done", 32'(busy), 32'd0);
    endtask

    task automatic rand_payload(input int i);
        logic [3:0] c;
        case ($urandom_range(0, 3))
            0: c = 4'd0;
            1: c = 4'd9;
            2: c = 4'd10;
            default: c = 4'($urandom_range(0, 15));
        endcase
        set_req(i, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), c,
                8'($urandom), 8'($urandom));
    endtask

    // Transaction model: an op granted in cycle x drives the ALU in x+1..x+lat,
    // responds from x+lat+1 and frees the scheduler the cycle after consumption.
    task automatic rand_phase(input int ncyc);
        int          rr, rsp_from, mid, gr, g, lat;
        bit          idle;
        logic [21:0] mexp;
        logic [7:0]  ma;
        logic [3:0]  er;
        rr = 0; rsp_from = 0; mid = 0; idle = 1'b1;
        mexp = '0; ma = '0;
        for (int x = 0; x < ncyc; x++) begin
            g  = -1;
            gr = -1;
            er = '0;
            if (idle)
                for (int k = 0; k < N; k++)
                    if (g < 0 && req_valid[2'((rr + k) % N)]) g = (rr + k) % N;
            if (g >= 0) er = 4'(1) << g;
            chk("rnd_ready", 32'(req_ready), 32'(er));
            chk("rnd_busy", 32'(busy), 32'(!idle));
            chk("rnd_ce", 32'(alu_ce), 32'(!idle && x < rsp_from));
            chk("rnd_valid", 32'(rsp_valid), 32'(!idle && x >= rsp_from));
            if (!idle && x < rsp_from)
                chk("rnd_opa", 32'(alu_opa), 32'(ma));
            if (!idle && x >= rsp_from) begin
                chk("rnd_id", 32'(rsp_id), 32'(mid));
                chk("rnd_res", 32'(rsp_res), 32'(mexp[15:0]));
                chk("rnd_flags", 32'(rsp_flags), 32'(mexp[21:16]));
            end
            if (idle && g >= 0) begin
                idle     = 1'b0;
                gr       = g;
                mid      = g;
                ma       = req_opa[g*8 +: 8];
                mexp     = alu_fn(req_mode[2'(g)], req_cin[2'(g)], req_cmd[g*4 +: 4],
                                  req_opa[g*8 +: 8], req_opb[g*8 +: 8]);
                lat      = lat_of(req_mode[2'(g)], req_cmd[g*4 +: 4]);
                rsp_from = x + lat + 1;
                rr       = (g + 1) % N;
            end else if (!idle && x >= rsp_from && rsp_ready) begin
                idle = 1'b1;
            end
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (i == gr) req_valid[2'(i)] = 1'b0;
                else if (!req_valid[2'(i)]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        rand_payload(i);
                        req_valid[2'(i)] = 1'b1;
                    end
                end else if ($urandom_range(0, 29) == 0) req_valid[2'(i)] = 1'b0;
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[5];
        int   g;
        int   n;

        vecs[0] = '{1, 1'b1, 1'b0, 4'd0,  8'h0F, 8'h01, 16'h0010, 6'h14, 1};
        vecs[1] = '{0, 1'b1, 1'b0, 4'd9,  8'h03, 8'h04, 16'h000C, 6'h12, 2};
        vecs[2] = '{2, 1'b1, 1'b0, 4'd10, 8'hFF, 8'hFF, 16'hFE01, 6'h11, 2};
        vecs[3] = '{3, 1'b0, 1'b0, 4'd9,  8'hF0, 8'h3C, 16'h0039, 6'h04, 1};
        vecs[4] = '{1, 1'b1, 1'b1, 4'd0,  8'hFF, 8'h01, 16'h0101, 6'h1C, 1};

        // Reset state
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_alu_ce", 32'(alu_ce), 32'd0);
        chk("rst_inp_valid", 32'(alu_inp_valid), 32'd0);
        chk("rst_rsp_res", 32'(rsp_res), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        do_reset();

        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // Reset in the middle of a multiply
        do_reset();
        set_req(2, 1'b1, 1'b0, 4'd9, 8'h07, 8'h07);
        req_valid = 4'b0100;
        #1;
        wait_grant(g);
        chk("mid_grant", 32'(g), 32'd2);
        @(negedge clk);
        req_valid = '0;
        #1;
        chk("mid_exec_ce", 32'(alu_ce), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_ce", 32'(alu_ce), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < N; i++) set_req(i, 1'b0, 1'b0, 4'd1, 8'(i), 8'h0F);
        req_valid = 4'b1111;
        #1;
        chk("post_rst_grant", 32'(req_ready), 32'h1);
        @(negedge clk);
        req_valid = '0;
        #1;
        wait_idle();

        // Round-robin with all requesters held
        do_reset();
        req_valid = 4'b1111;
        #1;
        for (int k = 0; k < 5; k++) begin
            wait_grant(g);
            chk("rr_grant", 32'(g), 32'(k % N));
            @(negedge clk);
            #1;
        end
        req_valid = '0;
        wait_idle();

        // Backpressure on the response
        do_reset();
        rsp_ready = 1'b0;
        set_req(1, 1'b1, 1'b0, 4'd0, 8'h0F, 8'h01);
        req_valid = 4'b0010;
        #1;
        wait_grant(g);
        chk("bp_grant", 32'(g), 32'd1);
        @(negedge clk);
        set_req(2, 1'b0, 1'b0, 4'd3, 8'h55, 8'hAA);
        req_valid = 4'b0100;
        #1;
        n = 0;
        while (!rsp_valid && n < 10) begin @(negedge clk); #1; n++; end
        repeat (5) begin
            chk("bp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_res", 32'(rsp_res), 32'h0010);
            chk("bp_id", 32'(rsp_id), 32'd1);
            chk("bp_ready", 32'(req_ready), 32'd0);
            chk("bp_ce", 32'(alu_ce), 32'd0);
            @(negedge clk);
            #1;
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("bp_idle", 32'(busy), 32'd0);
        chk("bp_released", 32'(rsp_valid), 32'd0);
        chk("bp_next_ready", 32'(req_ready), 32'h4);
        @(negedge clk);
        #1;
        chk("bp_next_ce", 32'(alu_ce), 32'd1);
        chk("bp_next_opa", 32'(alu_opa), 32'h55);
        req_valid = '0;
        wait_idle();

        // Grant skip: pointer sits at 2, only requester 1 asks
        do_reset();
        set_req(1, 1'b1, 1'b0, 4'd0, 8'h01, 8'h02);
        req_valid = 4'b0010;
        #1;
        wait_grant(g);
        chk("skip_first", 32'(g), 32'd1);
        @(negedge clk);
        req_valid = '0;
        #1;
        wait_idle();
        req_valid = 4'b0010;
        #1;
        wait_grant(g);
        chk("skip_grant", 32'(g), 32'd1);
        @(negedge clk);
        req_valid = '0;
        #1;
        wait_idle();
        set_req(3, 1'b1, 1'b0, 4'd0, 8'h02, 8'h02);
        req_valid = 4'b1010;
        #1;
        wait_grant(g);
        chk("skip_rr_ptr", 32'(g), 32'd3);
        @(negedge clk);
        req_valid = '0;
        #1;
        wait_idle();

        // Randomized traffic
        do_reset();
        @(negedge clk);
        rand_phase(1500);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
